wordgen_ctrl: RTL and testbench

Word-queue controller and scheduler sitting between the board switch/button inputs (sw1..sw4, write, auto) and the wordgen serializer. It debounces the write button, captures the 4-bit switch word into an 8-entry circular store, and offers stored words to the serializer over a valid/ready handshake. Manual mode drains the store once in FIFO order; auto mode replays the stored words in a loop without consuming them.

---
 rtl/wordgen_ctrl_if.sv | 15 +
 rtl/wordgen_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_wordgen_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wordgen_ctrl_if.sv
// Word handshake between the queue controller and the wordgen serializer.
//
// Handshake: a word transfers on every rising clock edge where word_valid
// and word_ready are both 1. Once the master raises word_valid it keeps
// word_valid and word_data unchanged until that transfer edge. The slave may
// drive word_ready at any time, and word_ready may depend on word_valid.
`timescale 1ns/1ps
interface wordgen_ctrl_if;
  logic [3:0] word_data;
  logic       word_valid;
  logic       word_ready;

  modport master (output word_data, output word_valid, input word_ready);
  modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/wordgen_ctrl.sv
// Word-queue controller: synchronizes and debounces the write button,
// captures the switch word into a circular store, and offers stored words
// to the serializer. Manual mode drains the store in FIFO order. Auto mode
// replays the stored words in a loop without consuming them.
`timescale 1ns/1ps
module wordgen_ctrl #(
  parameter int DEPTH      = 8,
  parameter int DEB_CYCLES = 50000
) (
  input  logic                       sysclk,
  input  logic                       rst_n,
  input  logic                       sw1,
  input  logic                       sw2,
  input  logic                       sw3,
  input  logic                       sw4,
  input  logic                       write,
  input  logic                       auto,
  wordgen_ctrl_if.master             wg,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic                       mode_auto,
  output logic [1:0]                 state_dbg
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = $clog2(DEB_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FIFO = 2'd1,
    S_LOOP = 2'd2
  } state_t;

  // Synchronizers and debounce
  logic          r_write_meta;
  logic          r_write_s;
  logic          r_auto_meta;
  logic          r_auto_s;
  logic          r_write_d;
  logic [DW-1:0] r_deb_cnt;

  // Store and pointers
  logic [3:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_play_ptr;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_overflow;

  // FSM and registered offer
  state_t        r_state;
  logic [3:0]    r_word_data;
  logic          r_word_valid;
  logic          r_mode_auto;

  // Combinational helpers
  logic [3:0]    w_sw;
  logic          w_deb_differ;
  logic          w_deb_flip;
  logic          w_cap_req;
  logic          w_cap_ok;
  logic          w_hs;
  logic          w_fifo_hs;
  logic [CW-1:0] w_count_next;
  logic [PW-1:0] w_loop_last;
  state_t        w_next_state;
  logic [PW-1:0] w_next_rd;
  logic [PW-1:0] w_next_play;
  logic [PW-1:0] w_fetch_ptr;
  logic          w_load;
  logic [3:0]    w_fetch_data;

  assign w_sw = {sw1, sw2, sw3, sw4};

  // The debounced level flips after the synchronized level has disagreed
  // with it for DEB_CYCLES+1 consecutive cycles; a capture is requested on
  // the 0->1 flip only, so holding the button yields one capture.
  assign w_deb_differ = (r_write_s != r_write_d);
  assign w_deb_flip   = w_deb_differ && (r_deb_cnt == DW'(DEB_CYCLES));
  assign w_cap_req    = w_deb_flip && r_write_s;

  assign w_hs      = r_word_valid && wg.word_ready;
  assign w_fifo_hs = (r_state == S_FIFO) && w_hs;

  // A full store still accepts a capture when a FIFO handshake frees a slot
  // on the same edge.
  assign w_cap_ok     = w_cap_req && (!r_full || w_fifo_hs);
  assign w_count_next = r_count + CW'(w_cap_ok) - CW'(w_fifo_hs);

  // Last loop slot uses the registered count, so words captured during the
  // loop join it from the following wrap.
  assign w_loop_last = r_rd_ptr + PW'(r_count - CW'(1));

  // The only slot that can be read on the same edge it is written is the
  // one right after a FIFO handshake that drains the last stored word.
  assign w_fetch_data = (w_cap_ok && (r_wr_ptr == w_fetch_ptr)) ? w_sw : r_mem[w_fetch_ptr];

  // Two-flop synchronizers for the asynchronous button and mode pins
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      r_write_meta <= 1'b0;
      r_write_s    <= 1'b0;
      r_auto_meta  <= 1'b0;
      r_auto_s     <= 1'b0;
    end else begin
      r_write_meta <= write;
      r_write_s    <= r_write_meta;
      r_auto_meta  <= auto;
      r_auto_s     <= r_auto_meta;
    end
  end

  // Debounce counter and debounced write level
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      r_deb_cnt <= '0;
      r_write_d <= 1'b0;
    end else if (!w_deb_differ) begin
      r_deb_cnt <= '0;
    end else if (w_deb_flip) begin
      r_deb_cnt <= '0;
      r_write_d <= r_write_s;
    end else begin
      r_deb_cnt <= r_deb_cnt + DW'(1);
    end
  end

  // Word store write port; contents are deliberately left out of reset
  always_ff @(posedge sysclk) begin
    if (rst_n && w_cap_ok) begin
      r_mem[r_wr_ptr] <= w_sw;
    end
  end

  // Pointers, occupancy and sticky overflow
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_play_ptr <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_cap_ok) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      r_rd_ptr   <= w_next_rd;
      r_play_ptr <= w_next_play;
      r_count    <= w_count_next;
      r_full     <= (w_count_next == CW'(DEPTH));
      r_empty    <= (w_count_next == '0);
      if (w_cap_req && !w_cap_ok) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state, pointer updates and which slot to offer next. The offer is
  // only reloaded when leaving IDLE or on a handshake, which keeps an
  // outstanding offer stable across mode changes and captures.
  always_comb begin
    w_next_state = r_state;
    w_next_rd    = r_rd_ptr;
    w_next_play  = r_play_ptr;
    w_fetch_ptr  = r_rd_ptr;
    w_load       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_load      = 1'b1;
          w_fetch_ptr = r_rd_ptr;
          if (r_auto_s) begin
            w_next_state = S_LOOP;
            w_next_play  = r_rd_ptr;
          end else begin
            w_next_state = S_FIFO;
          end
        end
      end
      S_FIFO: begin
        if (w_hs) begin
          w_next_rd = r_rd_ptr + PW'(1);
          if (w_count_next != '0) begin
            w_load      = 1'b1;
            w_fetch_ptr = w_next_rd;
            if (r_auto_s) begin
              w_next_state = S_LOOP;
              w_next_play  = w_next_rd;
            end else begin
              w_next_state = S_FIFO;
            end
          end else begin
            w_next_state = S_IDLE;
          end
        end
      end
      S_LOOP: begin
        if (w_hs) begin
          w_next_play = (r_play_ptr == w_loop_last) ? r_rd_ptr : (r_play_ptr + PW'(1));
          w_load      = 1'b1;
          if (!r_auto_s) begin
            w_next_state = S_FIFO;
            w_fetch_ptr  = r_rd_ptr;
          end else begin
            w_next_state = S_LOOP;
            w_fetch_ptr  = w_next_play;
          end
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Registered offer and mode flag derived from the next state
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      r_word_data  <= 4'd0;
      r_word_valid <= 1'b0;
      r_mode_auto  <= 1'b0;
    end else begin
      r_word_valid <= (w_next_state != S_IDLE);
      r_mode_auto  <= (w_next_state == S_LOOP);
      if (w_load) begin
        r_word_data <= w_fetch_data;
      end
    end
  end

  assign wg.word_data  = r_word_data;
  assign wg.word_valid = r_word_valid;
  assign count         = r_count;
  assign full          = r_full;
  assign empty         = r_empty;
  assign overflow      = r_overflow;
  assign mode_auto     = r_mode_auto;
  assign state_dbg     = r_state;

endmodule

// File: tb/tb_wordgen_ctrl.sv
// Bench for wordgen_ctrl with DEB_CYCLES=4: directed captures, debounce,
// manual drain, loop replay, full/overflow and mid-offer reset.
`timescale 1ns/1ps
module tb_wordgen_ctrl;

  localparam int DEPTH = 8;
  localparam int DEB   = 4;

  logic       sysclk;
  logic       rst_n;
  logic       sw1, sw2, sw3, sw4;
  logic       write;
  logic       auto;
  logic [3:0] count;
  logic       full, empty, overflow, mode_auto;
  logic [1:0] state_dbg;

  wordgen_ctrl_if wg_if ();

  wordgen_ctrl #(.DEPTH(DEPTH), .DEB_CYCLES(DEB)) dut (
    .sysclk   (sysclk),
    .rst_n    (rst_n),
    .sw1      (sw1),
    .sw2      (sw2),
    .sw3      (sw3),
    .sw4      (sw4),
    .write    (write),
    .auto     (auto),
    .wg       (wg_if),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .mode_auto(mode_auto),
    .state_dbg(state_dbg)
  );

  // Clock and watchdog
  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at %0t, expected finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance n rising edges, then step 1 ns past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  // Hold a word on the switches and press the button cleanly
  task automatic capture(input logic [3:0] w);
    {sw1, sw2, sw3, sw4} = w;
    write = 1'b1;
    tick(12);
    write = 1'b0;
    tick(12);
  endtask

  // Scoreboard monitor: a transfer happens at the next rising edge whenever
  // valid, ready and rst_n are all high mid-cycle.
  initial begin
    logic [3:0] exp_w;
    forever begin
      @(negedge sysclk);
      if (rst_n && wg_if.word_valid && wg_if.word_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL scoreboard: got word %b, expected no transfer", wg_if.word_data);
        end else begin
          exp_w = exp_q.pop_front();
          check("scoreboard_word", 32'(wg_if.word_data), 32'(exp_w));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    {sw1, sw2, sw3, sw4} = 4'b0000;
    write = 1'b0;
    auto  = 1'b0;
    wg_if.word_ready = 1'b0;
    tick(3);

    // Reset state
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_valid", 32'(wg_if.word_valid), 0);
    check("rst_data", 32'(wg_if.word_data), 0);
    check("rst_mode", 32'(mode_auto), 0);
    check("rst_state", 32'(state_dbg), 0);
    rst_n = 1'b1;
    tick(2);

    // Capture latency: count moves at edge 2+DEB after the first high sample
    {sw1, sw2, sw3, sw4} = 4'b1010;
    write = 1'b1;
    @(posedge sysclk);
    repeat (5) @(posedge sysclk);
    #1;
    check("lat_count_edge5", 32'(count), 0);
    tick(1);
    check("lat_count_edge6", 32'(count), 1);
    check("lat_valid_edge6", 32'(wg_if.word_valid), 0);
    tick(1);
    check("lat_valid_edge7", 32'(wg_if.word_valid), 1);
    check("lat_data_edge7", 32'(wg_if.word_data), 32'hA);
    check("lat_mode_edge7", 32'(mode_auto), 0);
    tick(13);
    write = 1'b0;
    tick(12);
    check("long_hold_single", 32'(count), 1);
    exp_q.push_back(4'b1010);
    wg_if.word_ready = 1'b1;
    tick(1);
    wg_if.word_ready = 1'b0;
    tick(2);
    check("drain1_empty", 32'(empty), 1);
    check("drain1_valid", 32'(wg_if.word_valid), 0);

    // Bouncing button never settles long enough to capture
    {sw1, sw2, sw3, sw4} = 4'b0111;
    for (int i = 0; i < 10; i++) begin
      write = ~write;
      tick(2);
    end
    write = 1'b0;
    tick(15);
    check("bounce_count", 32'(count), 0);
    check("bounce_empty", 32'(empty), 1);

    // Manual drain, one word per cycle
    for (int i = 1; i <= 3; i++) begin
      capture(4'(i));
      exp_q.push_back(4'(i));
    end
    check("manual_count", 32'(count), 3);
    check("manual_valid", 32'(wg_if.word_valid), 1);
    wg_if.word_ready = 1'b1;
    tick(3);
    check("manual_b2b_done_valid", 32'(wg_if.word_valid), 0);
    check("manual_b2b_done_empty", 32'(empty), 1);
    wg_if.word_ready = 1'b0;
    tick(2);

    // Auto loop replay without consuming
    auto = 1'b1;
    tick(4);
    capture(4'b1100);
    capture(4'b0101);
    check("loop_count", 32'(count), 2);
    check("loop_mode", 32'(mode_auto), 1);
    check("loop_first_data", 32'(wg_if.word_data), 32'hC);
    exp_q.push_back(4'b1100);
    exp_q.push_back(4'b0101);
    exp_q.push_back(4'b1100);
    exp_q.push_back(4'b0101);
    exp_q.push_back(4'b1100);
    for (int i = 0; i < 5; i++) begin
      wg_if.word_ready = 1'b1;
      tick(1);
      wg_if.word_ready = 1'b0;
      tick(1);
    end
    check("loop_count_kept", 32'(count), 2);
    auto = 1'b0;
    tick(4);
    check("loop_offer_held_mode", 32'(mode_auto), 1);
    check("loop_offer_held_data", 32'(wg_if.word_data), 32'h5);
    // Outstanding loop offer completes, then FIFO resumes at the read pointer
    exp_q.push_back(4'b0101);
    exp_q.push_back(4'b1100);
    exp_q.push_back(4'b0101);
    wg_if.word_ready = 1'b1;
    tick(3);
    wg_if.word_ready = 1'b0;
    tick(1);
    check("loop_exit_count", 32'(count), 0);
    check("loop_exit_empty", 32'(empty), 1);
    check("loop_exit_valid", 32'(wg_if.word_valid), 0);
    check("loop_exit_mode", 32'(mode_auto), 0);

    // Fill to capacity, then one dropped capture
    for (int i = 1; i <= 9; i++) begin
      capture(4'(i));
      if (i <= 8) exp_q.push_back(4'(i));
      if (i == 8) begin
        check("full_count", 32'(count), 8);
        check("full_flag", 32'(full), 1);
        check("full_no_overflow", 32'(overflow), 0);
      end
    end
    check("ovf_count", 32'(count), 8);
    check("ovf_flag", 32'(overflow), 1);

    // Capture landing on the same edge as a handshake while full
    {sw1, sw2, sw3, sw4} = 4'b1111;
    write = 1'b1;
    @(posedge sysclk);
    repeat (5) @(posedge sysclk);
    #1;
    wg_if.word_ready = 1'b1;
    tick(1);
    wg_if.word_ready = 1'b0;
    exp_q.push_back(4'b1111);
    check("coincide_count", 32'(count), 8);
    check("coincide_full", 32'(full), 1);
    write = 1'b0;
    tick(12);
    wg_if.word_ready = 1'b1;
    tick(10);
    wg_if.word_ready = 1'b0;
    tick(1);
    check("full_drain_count", 32'(count), 0);
    check("full_drain_empty", 32'(empty), 1);
    check("full_drain_overflow_sticky", 32'(overflow), 1);

    // Reset in the middle of an offer
    capture(4'b0110);
    check("midrst_valid_before", 32'(wg_if.word_valid), 1);
    check("midrst_data_before", 32'(wg_if.word_data), 32'h6);
    wg_if.word_ready = 1'b1;
    rst_n = 1'b0;
    tick(1);
    check("midrst_valid", 32'(wg_if.word_valid), 0);
    check("midrst_data", 32'(wg_if.word_data), 0);
    check("midrst_count", 32'(count), 0);
    check("midrst_empty", 32'(empty), 1);
    check("midrst_overflow", 32'(overflow), 0);
    check("midrst_mode", 32'(mode_auto), 0);
    check("midrst_state", 32'(state_dbg), 0);
    rst_n = 1'b1;
    wg_if.word_ready = 1'b0;
    tick(3);
    check("post_rst_valid", 32'(wg_if.word_valid), 0);
    check("post_rst_count", 32'(count), 0);

    check("queue_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
